// File: rtl/alu_exec_pipe.sv
// Two-stage pipelined decode-and-execute unit: operand register stage, combinational
// execute, then a result register stage that drives the outputs, with valid/ready on both sides.
module alu_exec_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [2:0]       sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic [TAG_W-1:0] out_tag,
    output logic             zero,
    output logic             carry,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [2:0] {
        OP_SUB = 3'b000,
        OP_ADD = 3'b001,
        OP_OR  = 3'b010,
        OP_AND = 3'b011,
        OP_ASR = 3'b100,
        OP_ROL = 3'b101,
        OP_SLT = 3'b110,
        OP_SEQ = 3'b111
    } op_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s1_v_r;
    logic [WIDTH-1:0] s1_rs_r;
    logic [WIDTH-1:0] s1_rt_r;
    op_e              s1_sel_r;
    logic [TAG_W-1:0] s1_tag_r;

    logic             s2_v_r;
    logic [WIDTH-1:0] s2_rd_r;
    logic [TAG_W-1:0] s2_tag_r;
    logic             s2_zero_r;
    logic             s2_carry_r;
    logic [CNT_W-1:0] done_cnt_r;

    logic             s2_adv_s;
    logic             accept_s;
    logic             out_hs_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic             lt_s;
    logic             eq_s;
    logic [WIDTH-1:0] ex_rd_s;
    logic             ex_carry_s;
    logic             ex_zero_s;

    // S2 may take a new op only when it is empty or is draining this cycle
    assign s2_adv_s = s1_v_r && (!s2_v_r || out_ready);
    assign in_ready = !s1_v_r || s2_adv_s;
    assign accept_s = in_valid && in_ready;
    assign out_hs_s = s2_v_r && out_ready;

    // Bit WIDTH of the widened difference is the borrow, i.e. rs < rt
    assign add_s = {1'b0, s1_rs_r} + {1'b0, s1_rt_r};
    assign sub_s = {1'b0, s1_rs_r} - {1'b0, s1_rt_r};
    assign lt_s  = (s1_rs_r < s1_rt_r);
    assign eq_s  = (s1_rs_r == s1_rt_r);

    // Execute: result and carry from the S1 operand registers
    always_comb begin
        ex_rd_s    = {WIDTH{1'b0}};
        ex_carry_s = 1'b0;
        case (s1_sel_r)
            OP_SUB: begin
                ex_rd_s    = sub_s[WIDTH-1:0];
                ex_carry_s = sub_s[WIDTH];
            end
            OP_ADD: begin
                ex_rd_s    = add_s[WIDTH-1:0];
                ex_carry_s = add_s[WIDTH];
            end
            OP_OR:   ex_rd_s = s1_rs_r | s1_rt_r;
            OP_AND:  ex_rd_s = s1_rs_r & s1_rt_r;
            OP_ASR:  ex_rd_s = {s1_rt_r[WIDTH-1], s1_rt_r[WIDTH-1:1]};
            OP_ROL:  ex_rd_s = {s1_rs_r[WIDTH-2:0], s1_rs_r[WIDTH-1]};
            OP_SLT:  ex_rd_s[3:0] = {3'b101, lt_s};
            OP_SEQ:  ex_rd_s[3:0] = {3'b111, eq_s};
            default: ex_rd_s = {WIDTH{1'b0}};
        endcase
    end

    assign ex_zero_s = (ex_rd_s == {WIDTH{1'b0}});

    // Stage 1: capture operands on accept, empty when the op moves on
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_r   <= 1'b0;
            s1_rs_r  <= {WIDTH{1'b0}};
            s1_rt_r  <= {WIDTH{1'b0}};
            s1_sel_r <= OP_SUB;
            s1_tag_r <= {TAG_W{1'b0}};
        end else if (accept_s) begin
            s1_v_r   <= 1'b1;
            s1_rs_r  <= rs;
            s1_rt_r  <= rt;
            s1_sel_r <= op_e'(sel);
            s1_tag_r <= in_tag;
        end else if (s2_adv_s) begin
            s1_v_r   <= 1'b0;
        end else begin
            s1_v_r   <= s1_v_r;
        end
    end

    // Stage 2: result register, held stable while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v_r     <= 1'b0;
            s2_rd_r    <= {WIDTH{1'b0}};
            s2_tag_r   <= {TAG_W{1'b0}};
            s2_zero_r  <= 1'b0;
            s2_carry_r <= 1'b0;
        end else if (s2_adv_s) begin
            s2_v_r     <= 1'b1;
            s2_rd_r    <= ex_rd_s;
            s2_tag_r   <= s1_tag_r;
            s2_zero_r  <= ex_zero_s;
            s2_carry_r <= ex_carry_s;
        end else if (out_hs_s) begin
            s2_v_r     <= 1'b0;
        end else begin
            s2_v_r     <= s2_v_r;
        end
    end

    // Completed-op counter; clear wins over a same-cycle handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            done_cnt_r <= {CNT_W{1'b0}};
        end else if (out_hs_s && (done_cnt_r != CNT_MAX)) begin
            done_cnt_r <= done_cnt_r + CNT_ONE;
        end else begin
            done_cnt_r <= done_cnt_r;
        end
    end

    assign out_valid = s2_v_r;
    assign rd        = s2_rd_r;
    assign out_tag   = s2_tag_r;
    assign zero      = s2_zero_r;
    assign carry     = s2_carry_r;
    assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Scoreboard bench: instance A (WIDTH=8, CNT_W=4) for directed vectors, stall, reset and
// counter cases; instance B (WIDTH=4) for an exhaustive sweep under random back-pressure.
module tb_alu_exec_pipe;

    localparam logic [2:0] SUB = 3'd0, ADD = 3'd1, OR_ = 3'd2, AND_ = 3'd3;
    localparam logic [2:0] ASR = 3'd4, ROL = 3'd5, SLT = 3'd6, SEQ = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_m = 0;
    bit sweep_on = 1'b0;

    typedef struct packed {
        logic [7:0] rd;
        logic [3:0] tag;
        logic       z;
        logic       c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    logic       a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic       a_zero, a_carry, a_cnt_clr;
    logic [7:0] a_rs, a_rt, a_rd;
    logic [2:0] a_sel;
    logic [3:0] a_in_tag, a_out_tag, a_done_cnt;

    logic       b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic       b_zero, b_carry, b_cnt_clr;
    logic [3:0] b_rs, b_rt, b_rd;
    logic [2:0] b_sel;
    logic [3:0] b_in_tag, b_out_tag, b_done_cnt;

    alu_exec_pipe #(.WIDTH(8), .TAG_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .rs(a_rs), .rt(a_rt), .sel(a_sel), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .rd(a_rd), .out_tag(a_out_tag),
        .zero(a_zero), .carry(a_carry), .cnt_clr(a_cnt_clr), .done_cnt(a_done_cnt)
    );

    alu_exec_pipe #(.WIDTH(4), .TAG_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .rs(b_rs), .rt(b_rt), .sel(b_sel), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .rd(b_rd), .out_tag(b_out_tag),
        .zero(b_zero), .carry(b_carry), .cnt_clr(b_cnt_clr), .done_cnt(b_done_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Behavioural 4-bit reference for the sweep
    function automatic exp_t model4(input logic [2:0] s, input logic [3:0] x, input logic [3:0] y,
                                    input logic [3:0] t);
        logic [4:0] sum;
        logic [3:0] r;
        logic       c;
        c = 1'b0;
        sum = {1'b0, x} + {1'b0, y};
        case (s)
            SUB:     begin r = x - y; c = (x < y); end
            ADD:     begin r = sum[3:0]; c = sum[4]; end
            OR_:     r = x | y;
            AND_:    r = x & y;
            ASR:     r = (y >> 1) | (y & 4'h8);
            ROL:     r = (x << 1) | (x >> 3);
            SLT:     r = (x < y) ? 4'hB : 4'hA;
            default: r = (x == y) ? 4'hF : 4'hE;
        endcase
        return '{rd: {4'h0, r}, tag: t, z: (r == 4'h0), c: c};
    endfunction

    // Monitor A: scoreboard pop on each out handshake, plus done_cnt reference
    always @(negedge clk) begin
        if (a_rst_n === 1'b1) begin
            chk("a_done_cnt", a_done_cnt, cnt_m);
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL a_unexpected: got rd=%0h tag=%0h, expected no output", a_rd, a_out_tag);
                end else begin
                    ea = qa.pop_front();
                    chk("a_rd", a_rd, ea.rd);
                    chk("a_tag", a_out_tag, ea.tag);
                    chk("a_zero", a_zero, ea.z);
                    chk("a_carry", a_carry, ea.c);
                end
            end
            if (a_cnt_clr) cnt_m = 0;
            else if (a_out_valid && a_out_ready && cnt_m < 15) cnt_m++;
        end else begin
            cnt_m = 0;
        end
    end

    // Monitor B: sweep scoreboard
    always @(negedge clk) begin
        if (b_rst_n === 1'b1 && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL b_unexpected: got rd=%0h, expected no output", b_rd);
            end else begin
                eb = qb.pop_front();
                chk("b_rd", b_rd, eb.rd[3:0]);
                chk("b_tag", b_out_tag, eb.tag);
                chk("b_zero", b_zero, eb.z);
                chk("b_carry", b_carry, eb.c);
            end
        end
    end

    // Random back-pressure on instance B during the sweep
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sweep_on) b_out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_a(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] t, input logic [7:0] r, input logic c);
        int k;
        a_in_valid = 1'b1; a_sel = s; a_rs = x; a_rt = y; a_in_tag = t;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (a_in_ready) break;
            @(posedge clk); #1;
        end
        if (k == 100) begin
            n_cmp++; n_err++;
            $display("FAIL a_accept_timeout: got in_ready=0 for 100 cycles, expected accept");
        end else begin
            qa.push_back('{rd: r, tag: t, z: (r == 8'h00), c: c});
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        for (int k = 0; k < 60 && qa.size() != 0; k++) @(posedge clk);
        #1;
        chk("a_drain", qa.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst_n = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_cnt_clr = 1'b0;
        a_rs = 8'h00; a_rt = 8'h00; a_sel = 3'd0; a_in_tag = 4'h0;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_cnt_clr = 1'b0;
        b_rs = 4'h0; b_rt = 4'h0; b_sel = 3'd0; b_in_tag = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_rd", a_rd, 0);
        chk("rst_tag", a_out_tag, 0);
        chk("rst_flags", {a_zero, a_carry}, 0);
        chk("rst_done_cnt", a_done_cnt, 0);

        // Latency and ADD carry
        send_a(ADD, 8'hF0, 8'h20, 4'h3, 8'h10, 1'b1);
        chk("lat_edge1", a_out_valid, 0);
        @(posedge clk); #1;
        chk("lat_edge2", a_out_valid, 1);
        drain_a();

        send_a(SUB, 8'h05, 8'h05, 4'h1, 8'h00, 1'b0);
        send_a(SUB, 8'h03, 8'h05, 4'h2, 8'hFE, 1'b1);
        send_a(AND_, 8'hF0, 8'h0F, 4'h4, 8'h00, 1'b0);
        send_a(OR_, 8'h0C, 8'h30, 4'h5, 8'h3C, 1'b0);
        send_a(ASR, 8'h00, 8'h81, 4'h6, 8'hC0, 1'b0);
        send_a(ASR, 8'hFF, 8'h42, 4'h7, 8'h21, 1'b0);
        send_a(ROL, 8'h81, 8'h00, 4'h8, 8'h03, 1'b0);
        send_a(SLT, 8'h03, 8'hC8, 4'h9, 8'h0B, 1'b0);
        send_a(SLT, 8'hC8, 8'h03, 4'hA, 8'h0A, 1'b0);
        send_a(SEQ, 8'h07, 8'h07, 4'hB, 8'h0F, 1'b0);
        send_a(SEQ, 8'h07, 8'h08, 4'hC, 8'h0E, 1'b0);
        send_a(ADD, 8'hFF, 8'h01, 4'hD, 8'h00, 1'b1);
        send_a(ADD, 8'h7F, 8'h01, 4'hE, 8'h80, 1'b0);
        send_a(SUB, 8'h00, 8'h01, 4'hF, 8'hFF, 1'b1);
        drain_a();

        // Stall: three back-to-back ops with consumer blocked
        a_out_ready = 1'b0;
        fork
            begin
                send_a(ADD, 8'h01, 8'h02, 4'h1, 8'h03, 1'b0);
                send_a(OR_, 8'h0C, 8'h30, 4'h2, 8'h3C, 1'b0);
                send_a(SUB, 8'h10, 8'h01, 4'h4, 8'h0F, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("stall_in_ready", a_in_ready, 0);
                chk("stall_out_valid", a_out_valid, 1);
                chk("stall_rd", a_rd, 8'h03);
                @(posedge clk); #1;
                chk("stall_rd_held", a_rd, 8'h03);
                chk("stall_tag_held", a_out_tag, 4'h1);
                a_out_ready = 1'b1;
            end
        join
        drain_a();

        // Reset with both stages full and an op offered during reset
        a_out_ready = 1'b0;
        send_a(OR_, 8'h01, 8'h02, 4'h5, 8'h03, 1'b0);
        send_a(AND_, 8'hFF, 8'h3C, 4'h6, 8'h3C, 1'b0);
        chk("full_in_ready", a_in_ready, 0);
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_sel = ADD; a_rs = 8'h11; a_rt = 8'h22; a_in_tag = 4'h9;
        a_rst_n = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1; a_in_valid = 1'b0;
        qa.delete();
        chk("rst2_out_valid", a_out_valid, 0);
        chk("rst2_in_ready", a_in_ready, 1);
        chk("rst2_done_cnt", a_done_cnt, 0);
        @(posedge clk); #1;
        chk("rst2_no_accept", a_out_valid, 0);
        send_a(ADD, 8'h22, 8'h11, 4'h7, 8'h33, 1'b0);
        drain_a();

        // Counter saturation and clear priority
        a_cnt_clr = 1'b1;
        @(posedge clk); #1;
        a_cnt_clr = 1'b0;
        chk("clr_done_cnt", a_done_cnt, 0);
        for (int i = 0; i < 17; i++) begin
            send_a(OR_, 8'(i), 8'h40, 4'(i), 8'(i) | 8'h40, 1'b0);
        end
        drain_a();
        chk("sat_done_cnt", a_done_cnt, 4'hF);
        send_a(ADD, 8'h01, 8'h01, 4'h7, 8'h02, 1'b0);
        @(posedge clk); #1;
        chk("clr_hs_valid", a_out_valid, 1);
        a_cnt_clr = 1'b1;
        @(posedge clk); #1;
        a_cnt_clr = 1'b0;
        chk("clr_hs_done_cnt", a_done_cnt, 0);
        drain_a();

        // Exhaustive WIDTH=4 sweep with random back-pressure
        sweep_on = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    int k;
                    b_in_valid = 1'b1; b_sel = 3'(s); b_rs = 4'(x); b_rt = 4'(y);
                    b_in_tag = 4'(x) ^ 4'(y);
                    for (k = 0; k < 100; k++) begin
                        @(negedge clk);
                        if (b_in_ready) break;
                        @(posedge clk); #1;
                    end
                    if (k == 100) begin
                        n_cmp++; n_err++;
                        $display("FAIL b_accept_timeout: got in_ready=0 for 100 cycles, expected accept");
                    end else begin
                        qb.push_back(model4(3'(s), 4'(x), 4'(y), 4'(x) ^ 4'(y)));
                    end
                    @(posedge clk); #1;
                end
            end
        end
        b_in_valid = 1'b0;
        sweep_on = 1'b0;
        b_out_ready = 1'b1;
        for (int k = 0; k < 60 && qb.size() != 0; k++) @(posedge clk);
        #1;
        chk("b_drain", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
